ahb_slave_interface: RTL

//  AHB-Lite responder at the AHB end of the AHB2APB bridge. It decodes the address phase, pipelines
//  the address and control into the data phase, and issues one request per transfer to the APB-side

---
 rtl/ahb_slave_interface.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ahb_slave_interface.sv
// AHB-Lite responder for the AHB2APB bridge: decodes the address phase, issues one
// request per transfer to the APB-side controller and stretches the data phase until it completes.
module ahb_slave_interface #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          SLOT_LOG2 = 26,
    parameter int          NUM_SLV   = 3
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [31:0]        haddr,
    input  logic [31:0]        hwdata,
    input  logic               hwrite,
    input  logic [1:0]         htrans,
    input  logic               hready_in,
    output logic               hr_readyout,
    output logic               hresp,
    output logic [31:0]        hr_data,
    output logic               xfer_valid,
    input  logic               xfer_ready,
    output logic [31:0]        xfer_addr,
    output logic               xfer_write,
    output logic [31:0]        xfer_wdata,
    output logic [NUM_SLV-1:0] xfer_sel,
    input  logic [31:0]        xfer_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    typedef struct packed {
        logic [31:0]        addr;
        logic               write;
        logic [NUM_SLV-1:0] sel;
    } req_t;

    state_t             state, state_nxt;
    req_t               req_q;
    logic [31:0]        slot;
    logic               in_range;
    logic [NUM_SLV-1:0] sel_dec;
    logic               addr_phase;
    logic               accept;
    logic               load_req;
    logic               handshake;

    // Below-base addresses must not wrap into the window, so the compare gates the subtraction.
    assign slot     = (haddr - BASE_ADDR) >> SLOT_LOG2;
    assign in_range = (haddr >= BASE_ADDR) && (slot < 32'(NUM_SLV));

    generate
        for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
            assign sel_dec[i] = in_range && (slot == 32'(i));
        end
    endgenerate

    // NONSEQ or SEQ only; IDLE and BUSY never start a transfer.
    assign addr_phase = hready_in && ((htrans == 2'b10) || (htrans == 2'b11));
    assign accept     = addr_phase &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2));
    assign handshake  = xfer_valid && xfer_ready;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        hr_readyout = 1'b1;
        hresp       = 1'b0;
        xfer_valid  = 1'b0;
        load_req    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                hresp = (state == ST_ERR2);
                if (accept) begin
                    if (in_range) begin
                        state_nxt = ST_REQ;
                        load_req  = 1'b1;
                    end else begin
                        state_nxt = ST_ERR1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                xfer_valid  = 1'b1;
                hr_readyout = 1'b0;
                if (xfer_ready) state_nxt = ST_DONE;
            end
            ST_ERR1: begin
                hr_readyout = 1'b0;
                hresp       = 1'b1;
                state_nxt   = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are only reloaded on an in-range accept, so they stay stable through REQ.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            req_q <= '0;
        end else if (load_req) begin
            req_q.addr  <= haddr;
            req_q.write <= hwrite;
            req_q.sel   <= sel_dec;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)                      hr_data <= '0;
        else if (handshake && !req_q.write) hr_data <= xfer_rdata;
    end

    assign xfer_addr  = req_q.addr;
    assign xfer_write = req_q.write;
    assign xfer_sel   = req_q.sel;
    assign xfer_wdata = xfer_valid ? hwdata : 32'h0;

endmodule
